// File: rtl/gpu_ddr_arbiter.sv
// Two-master Avalon-MM arbiter sharing one 64-bit DDR port: round-robin grant,
// write bursts hold the grant, read data is steered back through an in-order tag FIFO.
module gpu_ddr_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              i_nrst,
  input  logic [ADDR_W-1:0] i_m0_targetAddr,
  input  logic [2:0]        i_m0_burstLength,
  input  logic              i_m0_writeEnable,
  input  logic              i_m0_readEnable,
  input  logic [63:0]       i_m0_data,
  input  logic [7:0]        i_m0_byteEnable,
  output logic              o_m0_busy,
  output logic              o_m0_dataValid,
  output logic [63:0]       o_m0_data,
  input  logic [ADDR_W-1:0] i_m1_targetAddr,
  input  logic [2:0]        i_m1_burstLength,
  input  logic              i_m1_writeEnable,
  input  logic              i_m1_readEnable,
  input  logic [63:0]       i_m1_data,
  input  logic [7:0]        i_m1_byteEnable,
  output logic              o_m1_busy,
  output logic              o_m1_dataValid,
  output logic [63:0]       o_m1_data,
  output logic [ADDR_W-1:0] o_targetAddr,
  output logic [2:0]        o_burstLength,
  output logic              o_writeEnableMem,
  output logic              o_readEnableMem,
  output logic [63:0]       o_dataMem,
  output logic [7:0]        o_byteEnableMem,
  input  logic              i_busyMem,
  input  logic              i_dataValidMem,
  input  logic [63:0]       i_dataMem,
  output logic              o_errOrphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, WBURST} state_t;

  state_t           state, stateNext;
  logic             rr, rrNext;
  logic             lockId, lockIdNext;
  logic [2:0]       wcnt, wcntNext;
  logic [2:0]       rcnt;

  logic [PTR_W:0]   tagCount;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic             tagId    [TAG_DEPTH];
  logic [2:0]       tagBurst [TAG_DEPTH];
  logic             tagFull, tagEmpty, headId;
  logic [2:0]       headBurst;

  logic             m0Elig, m1Elig, grantValid, selId, selWr, selRd;
  logic [2:0]       selBurstEff;
  logic             accept, push, pop, retValid;

  assign tagFull   = (tagCount == (PTR_W+1)'(TAG_DEPTH));
  assign tagEmpty  = (tagCount == '0);
  assign headId    = tagId[rdPtr];
  assign headBurst = tagBurst[rdPtr];

  // State register
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      lockId <= 1'b0;
      wcnt   <= '0;
    end else begin
      state  <= stateNext;
      rr     <= rrNext;
      lockId <= lockIdNext;
      wcnt   <= wcntNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext  = state;
    rrNext     = rr;
    lockIdNext = lockId;
    wcntNext   = wcnt;
    case (state)
      IDLE: begin
        if (accept) begin
          rrNext = ~selId;
          if (o_writeEnableMem && selBurstEff > 3'd1) begin
            stateNext  = WBURST;
            lockIdNext = selId;
            wcntNext   = selBurstEff - 3'd1;
          end
        end
      end
      WBURST: begin
        if (accept) begin
          wcntNext = wcnt - 3'd1;
          if (wcnt <= 3'd1) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: grant selection, DDR mux, busy and read-return steering
  always_comb begin
    m0Elig     = i_m0_writeEnable | (i_m0_readEnable & ~tagFull);
    m1Elig     = i_m1_writeEnable | (i_m1_readEnable & ~tagFull);
    grantValid = 1'b0;
    selId      = rr;
    if (!i_nrst) begin
      grantValid = 1'b0;
    end else if (state == WBURST) begin
      grantValid = 1'b1;
      selId      = lockId;
    end else if (m0Elig && m1Elig) begin
      grantValid = 1'b1;
    end else if (m0Elig) begin
      grantValid = 1'b1;
      selId      = 1'b0;
    end else if (m1Elig) begin
      grantValid = 1'b1;
      selId      = 1'b1;
    end

    selWr           = selId ? i_m1_writeEnable : i_m0_writeEnable;
    selRd           = selId ? i_m1_readEnable  : i_m0_readEnable;
    o_targetAddr    = selId ? i_m1_targetAddr  : i_m0_targetAddr;
    o_burstLength   = selId ? i_m1_burstLength : i_m0_burstLength;
    o_dataMem       = selId ? i_m1_data        : i_m0_data;
    o_byteEnableMem = selId ? i_m1_byteEnable  : i_m0_byteEnable;
    selBurstEff     = (o_burstLength == 3'd0) ? 3'd1 : o_burstLength;

    o_writeEnableMem = grantValid & selWr;
    o_readEnableMem  = grantValid & (state == IDLE) & selRd;
    o_m0_busy        = ~(grantValid & ~selId) | i_busyMem;
    o_m1_busy        = ~(grantValid &  selId) | i_busyMem;
    accept           = (o_writeEnableMem | o_readEnableMem) & ~i_busyMem;

    retValid       = i_nrst & i_dataValidMem & ~tagEmpty;
    o_m0_dataValid = retValid & ~headId;
    o_m1_dataValid = retValid &  headId;
    o_m0_data      = i_dataMem;
    o_m1_data      = i_dataMem;

    push = accept & o_readEnableMem;
    pop  = retValid & (rcnt == headBurst - 3'd1);
  end

  // Tag storage holds {masterId, effective burst}; burst 0 is stored as 1
  always_ff @(posedge clk) begin
    if (push) begin
      tagId[wrPtr]    <= selId;
      tagBurst[wrPtr] <= selBurstEff;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      tagCount    <= '0;
      rcnt        <= '0;
      o_errOrphan <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tagCount <= tagCount + (PTR_W+1)'(1);
        2'b01:   tagCount <= tagCount - (PTR_W+1)'(1);
        default: tagCount <= tagCount;
      endcase
      if (pop)           rcnt <= '0;
      else if (retValid) rcnt <= rcnt + 3'd1;
      if (i_dataValidMem && tagEmpty) o_errOrphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpu_ddr_arbiter.sv
// Scoreboard bench for gpu_ddr_arbiter: directed master/DDR stimulus pushes expected
// DDR commands and read returns; a negedge monitor pops and compares them.
module tb_gpu_ddr_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [16:0] m0Addr, m1Addr;
  logic [2:0]  m0Burst, m1Burst;
  logic        m0We, m0Re, m1We, m1Re;
  logic [63:0] m0Wdata, m1Wdata;
  logic [7:0]  m0Be, m1Be;
  logic        m0Busy, m1Busy, m0Dv, m1Dv;
  logic [63:0] m0Rdata, m1Rdata;
  logic [16:0] memAddr;
  logic [2:0]  memBurst;
  logic        memWe, memRe;
  logic [63:0] memWdata;
  logic [7:0]  memBe;
  logic        busyMem, dvMem;
  logic [63:0] memRdata;
  logic        errOrphan;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          isWr;
    logic [16:0] addr;
    logic [2:0]  burst;
    logic [63:0] data;
    logic [7:0]  be;
  } ddrExp_t;

  typedef struct {
    bit          id;
    logic [63:0] data;
  } retExp_t;

  ddrExp_t ddrQ[$];
  retExp_t retQ[$];

  gpu_ddr_arbiter #(.ADDR_W(17), .TAG_DEPTH(4)) dut (
    .clk(clk), .i_nrst(nrst),
    .i_m0_targetAddr(m0Addr), .i_m0_burstLength(m0Burst),
    .i_m0_writeEnable(m0We), .i_m0_readEnable(m0Re),
    .i_m0_data(m0Wdata), .i_m0_byteEnable(m0Be),
    .o_m0_busy(m0Busy), .o_m0_dataValid(m0Dv), .o_m0_data(m0Rdata),
    .i_m1_targetAddr(m1Addr), .i_m1_burstLength(m1Burst),
    .i_m1_writeEnable(m1We), .i_m1_readEnable(m1Re),
    .i_m1_data(m1Wdata), .i_m1_byteEnable(m1Be),
    .o_m1_busy(m1Busy), .o_m1_dataValid(m1Dv), .o_m1_data(m1Rdata),
    .o_targetAddr(memAddr), .o_burstLength(memBurst),
    .o_writeEnableMem(memWe), .o_readEnableMem(memRe),
    .o_dataMem(memWdata), .o_byteEnableMem(memBe),
    .i_busyMem(busyMem), .i_dataValidMem(dvMem), .i_dataMem(memRdata),
    .o_errOrphan(errOrphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg;
    @(negedge clk);
  endtask

  task automatic expDdr(input bit w, input logic [16:0] a, input logic [2:0] b,
                        input logic [63:0] d, input logic [7:0] be);
    ddrExp_t e;
    e.isWr = w; e.addr = a; e.burst = b; e.data = d; e.be = be;
    ddrQ.push_back(e);
  endtask

  task automatic expRet(input bit id, input logic [63:0] d);
    retExp_t e;
    e.id = id; e.data = d;
    retQ.push_back(e);
  endtask

  task automatic idleMasters;
    m0We = 0; m0Re = 0; m1We = 0; m1Re = 0;
  endtask

  // Monitor: accepted DDR commands and master read beats
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if ((memWe || memRe) && !busyMem) begin
        tests++;
        if (ddrQ.size() == 0) begin
          fails++;
          $display("FAIL ddrCmd: unexpected cmd we=%0b addr=%h", memWe, memAddr);
        end else begin
          ddrExp_t e;
          e = ddrQ.pop_front();
          if (memWe !== e.isWr || memRe !== !e.isWr || memAddr !== e.addr ||
              memBurst !== e.burst || (e.isWr && (memWdata !== e.data || memBe !== e.be))) begin
            fails++;
            $display("FAIL ddrCmd: got we=%0b addr=%h burst=%0d data=%h be=%h expected we=%0b addr=%h burst=%0d data=%h be=%h",
                     memWe, memAddr, memBurst, memWdata, memBe, e.isWr, e.addr, e.burst, e.data, e.be);
          end
        end
      end
      if (m0Dv || m1Dv) begin
        tests++;
        if (retQ.size() == 0) begin
          fails++;
          $display("FAIL readRet: unexpected dv m0=%0b m1=%0b data=%h", m0Dv, m1Dv, memRdata);
        end else begin
          retExp_t r;
          logic [63:0] got;
          r = retQ.pop_front();
          got = r.id ? m1Rdata : m0Rdata;
          if (m0Dv !== !r.id || m1Dv !== r.id || got !== r.data) begin
            fails++;
            $display("FAIL readRet: got dv0=%0b dv1=%0b data=%h expected master=%0d data=%h",
                     m0Dv, m1Dv, got, r.id, r.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 0; idleMasters();
    m0Addr = '0; m1Addr = '0; m0Burst = 3'd1; m1Burst = 3'd1;
    m0Wdata = '0; m1Wdata = '0; m0Be = 8'hF0; m1Be = 8'h0F;
    busyMem = 0; dvMem = 0; memRdata = '0;

    // Reset holds outputs quiet even with requests and return data present
    m0Re = 1; dvMem = 1;
    tick(); tick();
    atNeg();
    check("rstBusy0", m0Busy, 1);
    check("rstBusy1", m1Busy, 1);
    check("rstRdEn", memRe, 0);
    check("rstDv", {m0Dv, m1Dv}, 0);
    m0Re = 0; dvMem = 0; nrst = 1;
    tick();
    atNeg();
    check("idleBusy", {m0Busy, m1Busy}, 2'b11);
    check("idleEn", {memWe, memRe}, 0);
    check("idleOrphan", errOrphan, 0);
    tick();

    // Simultaneous single-beat reads: M0 first (rr=0), then M1
    m0Addr = 17'h10; m0Burst = 1; m0Re = 1;
    m1Addr = 17'h20; m1Burst = 1; m1Re = 1;
    expDdr(0, 17'h10, 1, 0, 0); expDdr(0, 17'h20, 1, 0, 0);
    expRet(0, 64'h1111_0000_0000_00D0); expRet(1, 64'h2222_0000_0000_00D1);
    atNeg();
    check("rdC0busy0", m0Busy, 0);
    check("rdC0busy1", m1Busy, 1);
    tick(); m0Re = 0;
    atNeg();
    check("rdC1busy1", m1Busy, 0);
    tick(); m1Re = 0;
    dvMem = 1; memRdata = 64'h1111_0000_0000_00D0;
    tick(); memRdata = 64'h2222_0000_0000_00D1;
    tick(); dvMem = 0;

    // 4-beat M0 write with M1 read pending; DDR stalls beat 2 for two cycles
    m0Addr = 17'h100; m0Burst = 4; m0We = 1;
    m1Addr = 17'h200; m1Burst = 2; m1Re = 1;
    for (int b = 0; b < 4; b++) expDdr(1, 17'h100, 4, 64'hA + 64'(b), 8'hF0);
    expDdr(0, 17'h200, 2, 0, 0); expDdr(0, 17'h180, 1, 0, 0);
    for (int b = 0; b < 4; b++) begin
      m0Wdata = 64'hA + 64'(b);
      if (b == 2) begin
        for (int s = 0; s < 2; s++) begin
          busyMem = 1;
          atNeg();
          check("wbStallBusy1", m1Busy, 1);
          check("wbStallBusy0", m0Busy, 1);
          tick();
        end
      end
      busyMem = 0;
      atNeg();
      check("wbBusy1", m1Busy, 1);
      tick();
    end
    m0We = 0; m0Addr = 17'h180; m0Burst = 1; m0Re = 1;
    atNeg();
    check("postBurstRdM1", {m1Busy, memRe}, 2'b01);
    check("postBurstBusy0", m0Busy, 1);
    tick(); m1Re = 0;
    atNeg();
    check("postBurstRdM0", m0Busy, 0);
    tick(); m0Re = 0;
    expRet(1, 64'hE0); expRet(1, 64'hE1); expRet(0, 64'hE2);
    dvMem = 1;
    for (int i = 0; i < 3; i++) begin
      memRdata = 64'hE0 + 64'(i);
      tick();
    end
    dvMem = 0;

    // Tag FIFO full: 5th read waits until the first return pops
    m1Burst = 1; m1Re = 1;
    for (int i = 0; i < 5; i++) begin
      expDdr(0, 17'h300 + 17'(i), 1, 0, 0);
      expRet(1, 64'hF0 + 64'(i));
    end
    for (int i = 0; i < 4; i++) begin
      m1Addr = 17'h300 + 17'(i);
      atNeg();
      check("fillBusy1", m1Busy, 0);
      tick();
    end
    m1Addr = 17'h304;
    for (int i = 0; i < 2; i++) begin
      atNeg();
      check("fullBusy1", m1Busy, 1);
      check("fullRdEn", memRe, 0);
      tick();
    end
    dvMem = 1; memRdata = 64'hF0;
    atNeg();
    check("popCycleBusy1", m1Busy, 1);
    tick(); dvMem = 0;
    atNeg();
    check("afterPopBusy1", m1Busy, 0);
    check("afterPopRdEn", memRe, 1);
    tick(); m1Re = 0;
    dvMem = 1;
    for (int i = 1; i < 5; i++) begin
      memRdata = 64'hF0 + 64'(i);
      tick();
    end
    dvMem = 0;

    // Orphan return: no dataValid, sticky error
    dvMem = 1; memRdata = 64'hDEAD;
    atNeg();
    check("orphanDv", {m0Dv, m1Dv}, 0);
    check("orphanPre", errOrphan, 0);
    tick(); dvMem = 0;
    atNeg();
    check("orphanSet", errOrphan, 1);
    tick(); tick();
    atNeg();
    check("orphanSticky", errOrphan, 1);
    tick();

    // Reset mid-burst (wcnt=2) with a read outstanding
    m1Addr = 17'h500; m1Burst = 1; m1Re = 1;
    expDdr(0, 17'h500, 1, 0, 0);
    tick(); m1Re = 0;
    m0Addr = 17'h400; m0Burst = 3; m0We = 1; m0Wdata = 64'h11;
    expDdr(1, 17'h400, 3, 64'h11, 8'hF0);
    tick();
    m0Wdata = 64'h12; nrst = 0;
    atNeg();
    check("midRstBusy", {m0Busy, m1Busy}, 2'b11);
    check("midRstWe", memWe, 0);
    tick();
    nrst = 1; m0We = 0;
    m1Addr = 17'h600; m1Burst = 1; m1We = 1; m1Wdata = 64'h77;
    expDdr(1, 17'h600, 1, 64'h77, 8'h0F);
    atNeg();
    check("postRstBusy1", m1Busy, 0);
    check("postRstWe", memWe, 1);
    check("postRstOrphan", errOrphan, 0);
    tick(); m1We = 0;
    dvMem = 1; memRdata = 64'hBEEF;
    atNeg();
    check("lateDv", {m0Dv, m1Dv}, 0);
    tick(); dvMem = 0;
    atNeg();
    check("lateOrphan", errOrphan, 1);
    tick();

    check("ddrQEmpty", 64'(ddrQ.size()), 0);
    check("retQEmpty", 64'(retQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
